// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared constants and FSM state type for the interrupt controller
//
// Contents:
//   OFF_*        byte offsets of the registers from the block base address
//   CTRL_*       bit positions inside CTRL
//   CAUSE_VALID  bit position of the VALID flag inside CAUSE
//   state_t      service FSM states
package intr_pkg;

  localparam logic [3:0] OFF_PEND  = 4'h0;
  localparam logic [3:0] OFF_MASK  = 4'h2;
  localparam logic [3:0] OFF_CTRL  = 4'h4;
  localparam logic [3:0] OFF_CAUSE = 4'h6;
  localparam logic [3:0] OFF_EOI   = 4'h8;

  localparam int CTRL_GIE    = 0;
  localparam int CTRL_INSVC  = 1;
  localparam int CAUSE_VALID = 15;

  typedef enum logic {
    IDLE = 1'b0,
    SVC  = 1'b1
  } state_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// rtl/intr_ctrl_if.sv - device bus and CPU handshake bundle of the interrupt controller
//
// Signals:
//   abus     bus address
//   wbus     write data
//   re, we   read / write enables
//   intr_in  device interrupt lines, bit 0 highest priority
//   iack     CPU acknowledge pulse
//   irq      registered interrupt request to the CPU
//   insvc    an interrupt is in service
// Modports: slave (the controller), master (the bus / CPU side).
interface intr_ctrl_if #(
  parameter int ABITS = 32,
  parameter int DBITS = 32,
  parameter int NSRC  = 4
) ();

  logic [ABITS-1:0] abus;
  logic [DBITS-1:0] wbus;
  logic             re;
  logic             we;
  logic [NSRC-1:0]  intr_in;
  logic             iack;
  logic             irq;
  logic             insvc;

  modport slave (
    input  abus, wbus, re, we, intr_in, iack,
    output irq, insvc
  );

  modport master (
    output abus, wbus, re, we, intr_in, iack,
    input  irq, insvc
  );

endinterface

// File: rtl/intr_prio_enc.sv
// rtl/intr_prio_enc.sv - combinational lowest-index-first priority encoder
//
// Ports:
//   req  in   NSRC  request vector, bit 0 has highest priority
//   id   out  IDB   index of the lowest set bit (0 when none)
//   any  out  1     at least one request bit is set
module intr_prio_enc #(
  parameter int NSRC = 4,
  parameter int IDB  = 2
) (
  input  logic [NSRC-1:0] req,
  output logic [IDB-1:0]  id,
  output logic            any
);

  // Scan from the top down so the lowest set index is the last to win.
  always_comb begin
    id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = IDB'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - memory-mapped interrupt controller with IACK/EOI service tracking
//
// Ports:
//   clk    in     1      system clock, rising edge
//   rst_n  in     1      asynchronous reset, active-low
//   lock   in     1      PLL lock; while 0 all state holds
//   bus    slave  -      intr_ctrl_if: abus/wbus/re/we, intr_in, iack, irq, insvc
//   rbus   inout  DBITS  read data, driven only while this block is read, else 'z
// Registers (byte offsets from RBASE): PEND +0, MASK +2, CTRL +4 (GIE, INSVC),
//   CAUSE +6 (VALID bit 15, ID), EOI +8 (write-only).
// Build option: INTC_EDGE_EN selects edge-latched PEND with write-1-to-clear;
//   undefined gives level mode where PEND follows intr_in one cycle late.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int               ABITS = 32,
  parameter int               DBITS = 32,
  parameter logic [ABITS-1:0] RBASE = ABITS'(32'hF000_0800),
  parameter int               NSRC  = 4,
  parameter int               IDB   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lock,
  intr_ctrl_if.slave       bus,
  inout  wire  [DBITS-1:0] rbus
);

  state_t           state_q, state_d;
  logic [NSRC-1:0]  pend_q, pend_d;
  logic [NSRC-1:0]  mask_q;
  logic             gie_q;
  logic             irq_q, irq_d;
  logic             cause_valid_q, cause_valid_d;
  logic [IDB-1:0]   cause_id_q, cause_id_d;

  logic [NSRC-1:0]  req;
  logic [IDB-1:0]   req_id;
  logic             req_any;

  logic             sel_pend, sel_mask, sel_ctrl, sel_cause, sel_eoi;
  logic             wr_mask, wr_ctrl, wr_eoi;
  logic             rd_hit;
  logic [DBITS-1:0] rd_data;

  // Address decode: exact byte-offset match within the register block.
  assign sel_pend  = (bus.abus == RBASE + ABITS'(OFF_PEND));
  assign sel_mask  = (bus.abus == RBASE + ABITS'(OFF_MASK));
  assign sel_ctrl  = (bus.abus == RBASE + ABITS'(OFF_CTRL));
  assign sel_cause = (bus.abus == RBASE + ABITS'(OFF_CAUSE));
  assign sel_eoi   = (bus.abus == RBASE + ABITS'(OFF_EOI));

  assign wr_mask = bus.we & sel_mask;
  assign wr_ctrl = bus.we & sel_ctrl;
  assign wr_eoi  = bus.we & sel_eoi;

  // Arbitration always sees the registered PEND/MASK, so a same-cycle
  // MASK or CTRL write cannot change which source an IACK picks.
  assign req = pend_q & mask_q;

  intr_prio_enc #(
    .NSRC (NSRC),
    .IDB  (IDB)
  ) u_prio (
    .req (req),
    .id  (req_id),
    .any (req_any)
  );

`ifdef INTC_EDGE_EN
  logic            wr_pend;
  logic [NSRC-1:0] pend_clr;
  logic [NSRC-1:0] intr_prev_q;

  assign wr_pend  = bus.we & sel_pend;
  assign pend_clr = wr_pend ? bus.wbus[NSRC-1:0] : '0;
  // The clear is applied first so a new rising edge in the same cycle wins.
  assign pend_d   = (pend_q & ~pend_clr) | (bus.intr_in & ~intr_prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_prev_q <= '0;
    end else if (lock) begin
      intr_prev_q <= bus.intr_in;
    end
  end
`else
  assign pend_d = bus.intr_in;
`endif

  // Upper write-data bits carry no register state.
  logic unused_wbus;
  assign unused_wbus = ^bus.wbus[DBITS-1:NSRC];

  // Service FSM next state, IRQ and CAUSE.
  always_comb begin
    state_d       = state_q;
    irq_d         = 1'b0;
    cause_valid_d = cause_valid_q;
    cause_id_d    = cause_id_q;
    case (state_q)
      IDLE: begin
        irq_d = gie_q & req_any;
        if (bus.iack) begin
          if (req_any) begin
            cause_valid_d = 1'b1;
            cause_id_d    = req_id;
            state_d       = SVC;
            irq_d         = 1'b0;
          end else begin
            // Spurious acknowledge: report no valid source, stay idle.
            cause_valid_d = 1'b0;
            cause_id_d    = '1;
          end
        end
      end
      SVC: begin
        if (wr_eoi) begin
          state_d       = IDLE;
          cause_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pend_q        <= '0;
      mask_q        <= '0;
      gie_q         <= 1'b0;
      irq_q         <= 1'b0;
      cause_valid_q <= 1'b0;
      cause_id_q    <= '0;
    end else if (lock) begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      irq_q         <= irq_d;
      cause_valid_q <= cause_valid_d;
      cause_id_q    <= cause_id_d;
      if (wr_mask) begin
        mask_q <= bus.wbus[NSRC-1:0];
      end
      if (wr_ctrl) begin
        gie_q <= bus.wbus[CTRL_GIE];
      end
    end
  end

  assign bus.irq   = irq_q;
  assign bus.insvc = (state_q == SVC);

  // Combinational read mux; EOI is decoded so reads of it return 0 on the bus.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    if (bus.re) begin
      if (sel_pend) begin
        rd_hit              = 1'b1;
        rd_data[NSRC-1:0]   = pend_q;
      end else if (sel_mask) begin
        rd_hit              = 1'b1;
        rd_data[NSRC-1:0]   = mask_q;
      end else if (sel_ctrl) begin
        rd_hit              = 1'b1;
        rd_data[CTRL_GIE]   = gie_q;
        rd_data[CTRL_INSVC] = (state_q == SVC);
      end else if (sel_cause) begin
        rd_hit               = 1'b1;
        rd_data[CAUSE_VALID] = cause_valid_q;
        rd_data[IDB-1:0]     = cause_id_q;
      end else if (sel_eoi) begin
        rd_hit = 1'b1;
      end
    end
  end

  assign rbus = rd_hit ? rd_data : {DBITS{1'bz}};

endmodule
